cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Sequencing FSM for the direct-mapped write-back cache: accepts CPU read/write requests, performs tag lookup,
//  and on a miss writes back the dirty victim block and then refills the line, word-serially, over a req/ack memory port.
//  Owns the tag, valid, dirty and data arrays; sits between the CPU and the main-memory model.
// PARAMETERS
//  addrSize  24    word-address width (tag+index+offset)
//  cacheSize 1024  number of cache lines (power of 2)
//  nWords    16    words per block (power of 2)
//  sWord     32    word width in bits
// PORTS
//  clk         in   1         clock, all logic on posedge
//  rst         in   1         synchronous reset, active-high
//  cpu_req     in   1         request valid; accepted when cpu_req & cpu_ready
//  cpu_we      in   1         1 = write, 0 = read (sampled on accept)
//  cpu_addr    in   addrSize  word address {tag,index,offset}
//  cpu_wdata   in   sWord     write data
//  cpu_ready   out  1         controller in IDLE, can accept
//  cpu_valid   out  1         one-cycle pulse: request complete
//  cpu_rdata   out  sWord     read data (write: the written word), valid with cpu_valid
//  mem_req     out  1         memory word transfer request, held until mem_ack
//  mem_we      out  1         1 = write-back word, 0 = refill read
//  mem_addr    out  addrSize  {tag,index,word_cnt}
//  mem_wdata   out  sWord     write-back word
//  mem_rdata   in   sWord     refill word, valid with mem_ack
//  mem_ack     in   1         transfer done this cycle; ignored while mem_req=0
//  hit_count, miss_count, wb_count  out  32 each  statistics (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, cpu_ready=1, cpu_valid=0, mem_req=0, mem_we=0, word_cnt=0, all valid/dirty bits=0; tag/data not cleared.
//  - States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
//  - IDLE: on accept, latch cpu_we/addr/wdata -> LOOKUP; cpu_ready=1 only in IDLE; cpu_req in other states ignored.
//  - LOOKUP: hit = valid[idx] & tag[idx]==tag.
//      Hit read: rdata=data[idx][off]. Hit write: data[idx][off]=wdata, dirty[idx]=1, rdata=wdata. Both -> RESPOND.
//      Miss & valid & dirty -> WRITEBACK; otherwise miss -> REFILL. word_cnt=0.
//  - WRITEBACK: mem_req=1, mem_we=1, mem_addr={tag[idx],idx,word_cnt}, mem_wdata=data[idx][word_cnt].
//      Each mem_ack: word_cnt++. Ack on word nWords-1: dirty[idx]=0, word_cnt=0 -> REFILL.
//  - REFILL: on entry valid[idx]=0. mem_req=1, mem_we=0, mem_addr={tag,idx,word_cnt}.
//      Each mem_ack: data[idx][word_cnt]=mem_rdata, word_cnt++. Ack on last word: tag[idx]=tag, valid=1, dirty=0 -> LOOKUP.
//      The retried lookup always hits.
//  - RESPOND: cpu_valid=1 for exactly one cycle -> IDLE.
//  - Latency: hit = accept at T, cpu_valid at T+2.
//      Clean miss = T+2+nWords*(ack delay)+2 minimum. Dirty miss adds nWords more transfers.
//  - mem_addr/mem_we/mem_wdata held stable while mem_req=1 and no ack; mem_req deasserts the cycle after the last ack.
//      Back-to-back acks are legal: one word per cycle.
//  - word_cnt width = log2(nWords); its wrap to 0 occurs only on the last ack.
//  - rst mid-operation wins over everything: the next state is IDLE and mem_req drops the cycle after rst.
//      An in-progress write-back is abandoned (data lost); there is no cpu_valid for the aborted request.
// CONFIGURATION
//  CACHE_STATS_EN defined: hit_count / miss_count / wb_count increment by one in LOOKUP (hit only on the first lookup;
//    a post-refill retry is not counted) and at WRITEBACK completion. The counters saturate at 32'hFFFFFFFF and are cleared by rst.
//  CACHE_STATS_EN undefined: the three ports are tied to 0 and no counter logic is present.
// TESTING  (addrSize=8, cacheSize=4, nWords=4, sWord=32; mem model: word i at addr a = 32'h1000+a)
//  1. After rst, read 0x05 -> miss; mem reads of 0x04..0x07 in order; cpu_ready=0 throughout; cpu_rdata=32'h1005.
//  2. Read 0x06 next -> hit; cpu_valid exactly 2 cycles after accept; mem_req stays 0.
//  3. Write 0x06=32'hDEADBEEF, then read 0x46 (same index, tag 4) -> 4 write-backs to 0x04..0x07, with
//     0x06 carrying DEADBEEF; then refill 0x44..0x47; cpu_rdata=32'h1046.
//  4. mem_ack delayed 3 cycles per word -> mem_addr and mem_wdata stable while waiting; word_cnt does not advance; result correct.
//  5. rst asserted during refill word 2 -> next cycle: IDLE, mem_req=0, cpu_ready=1, no cpu_valid;
//     a re-read of the same address misses.
//  6. CACHE_STATS_EN defined, sequence 1-3 -> hit_count=2, miss_count=2, wb_count=1; undefined -> all 0.

Source files
------------

// File: rtl/cache_controller_if.sv
// CPU and memory-side handshake bundle for the cache controller, plus its statistics outputs.
// slave = controller view (takes CPU requests, issues memory transfers); master = environment view.
// No logic here; flow control is req/ready on the CPU side and req/ack on the memory side.
interface cache_controller_if #(
  parameter int addrSize = 24,
  parameter int sWord    = 32
);
  logic                cpu_req;
  logic                cpu_we;
  logic [addrSize-1:0] cpu_addr;
  logic [sWord-1:0]    cpu_wdata;
  logic                cpu_ready;
  logic                cpu_valid;
  logic [sWord-1:0]    cpu_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [addrSize-1:0] mem_addr;
  logic [sWord-1:0]    mem_wdata;
  logic [sWord-1:0]    mem_rdata;
  logic                mem_ack;
  logic [31:0]         hit_count;
  logic [31:0]         miss_count;
  logic [31:0]         wb_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_ready, cpu_valid, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output hit_count, miss_count, wb_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_ready, cpu_valid, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped write-back cache sequencer: lookup, dirty-victim write-back, word-serial refill.
// Latency: hit = accept at T, cpu_valid at T+2; misses add one memory transfer per word moved.
// Backpressure: cpu_ready only in IDLE; each memory word is held on the bus until mem_ack.
// Optional statistics counters are enabled by defining CACHE_STATS_EN.
module cache_controller #(
  parameter int addrSize  = 24,
  parameter int cacheSize = 1024,
  parameter int nWords    = 16,
  parameter int sWord     = 32
) (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
);
  localparam int offBits  = $clog2(nWords);
  localparam int idxBits  = $clog2(cacheSize);
  localparam int tagBits  = addrSize - idxBits - offBits;
  localparam int nEntries = cacheSize * nWords;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

  state_t                 state_q, state_d;
  logic [offBits-1:0]     word_cnt_q, word_cnt_d;
  logic                   we_q, we_d;
  logic [addrSize-1:0]    addr_q, addr_d;
  logic [sWord-1:0]       wdata_q, wdata_d;
  logic                   retry_q, retry_d;
  logic                   cpu_ready_q, cpu_ready_d;
  logic                   cpu_valid_q, cpu_valid_d;
  logic [sWord-1:0]       cpu_rdata_q, cpu_rdata_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [addrSize-1:0]    mem_addr_q, mem_addr_d;
  logic [sWord-1:0]       mem_wdata_q, mem_wdata_d;
  logic [cacheSize-1:0]   valid_q, valid_d;
  logic [cacheSize-1:0]   dirty_q, dirty_d;

  // Tag and data storage; never reset, only qualified by valid_q.
  logic [tagBits-1:0]     tag_mem  [cacheSize];
  logic [sWord-1:0]       data_mem [nEntries];

  logic [tagBits-1:0]     req_tag;
  logic [idxBits-1:0]     req_idx;
  logic [offBits-1:0]     req_off;
  logic                   hit, ack, last_word;
  logic                   data_we, tag_we;
  logic [idxBits+offBits-1:0] data_waddr;
  logic [sWord-1:0]       data_wdat;
  logic                   hit_inc, miss_inc, wb_inc;

  assign {req_tag, req_idx, req_off} = addr_q;
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign ack       = mem_req_q && bus.mem_ack;
  assign last_word = &word_cnt_q;

  // Next-state, array-update and registered-output computation.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    retry_d     = retry_q;
    cpu_rdata_d = cpu_rdata_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    data_we     = 1'b0;
    data_waddr  = {req_idx, req_off};
    data_wdat   = wdata_q;
    tag_we      = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    wb_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          retry_d = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        word_cnt_d = '0;
        if (hit) begin
          // A lookup retried after refill is not a fresh hit.
          hit_inc = !retry_q;
          if (we_q) begin
            data_we          = 1'b1;
            dirty_d[req_idx] = 1'b1;
            cpu_rdata_d      = wdata_q;
          end else begin
            cpu_rdata_d = data_mem[{req_idx, req_off}];
          end
          state_d = RESPOND;
        end else begin
          miss_inc = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = WRITEBACK;
          end else begin
            valid_d[req_idx] = 1'b0;
            state_d          = REFILL;
          end
        end
      end
      WRITEBACK: begin
        if (ack) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (last_word) begin
            dirty_d[req_idx] = 1'b0;
            valid_d[req_idx] = 1'b0;
            wb_inc           = 1'b1;
            state_d          = REFILL;
          end
        end
      end
      REFILL: begin
        if (ack) begin
          data_we    = 1'b1;
          data_waddr = {req_idx, word_cnt_q};
          data_wdat  = bus.mem_rdata;
          word_cnt_d = word_cnt_q + 1'b1;
          if (last_word) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b0;
            retry_d          = 1'b1;
            state_d          = LOOKUP;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state, so they change only on state/word transitions.
    cpu_ready_d = (state_d == IDLE);
    cpu_valid_d = (state_d == RESPOND);
    mem_req_d   = (state_d == WRITEBACK) || (state_d == REFILL);
    mem_we_d    = (state_d == WRITEBACK);
    mem_addr_d  = {(state_d == WRITEBACK) ? tag_mem[req_idx] : req_tag, req_idx, word_cnt_d};
    mem_wdata_d = data_mem[{req_idx, word_cnt_d}];
  end

  // FSM state, request latch, valid/dirty bits and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      retry_q     <= 1'b0;
      cpu_ready_q <= 1'b1;
      cpu_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      retry_q     <= retry_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Tag/data array writes; suppressed under reset so an aborted refill leaves no partial tag.
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_mem[data_waddr] <= data_wdat;
    if (!rst && tag_we)  tag_mem[req_idx]     <= req_tag;
  end

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_valid = cpu_valid_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q, wb_count_d;

  // Saturating event counters.
  always_comb begin
    hit_count_d  = (hit_inc  && hit_count_q  != 32'hFFFF_FFFF) ? hit_count_q  + 32'd1 : hit_count_q;
    miss_count_d = (miss_inc && miss_count_q != 32'hFFFF_FFFF) ? miss_count_q + 32'd1 : miss_count_q;
    wb_count_d   = (wb_inc   && wb_count_q   != 32'hFFFF_FFFF) ? wb_count_q   + 32'd1 : wb_count_q;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
  assign bus.wb_count   = wb_count_q;
`else
  logic unused_stats;
  assign unused_stats   = hit_inc ^ miss_inc ^ wb_inc;
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
  assign bus.wb_count   = '0;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Directed + randomized bench for cache_controller against a transaction-level cache/memory model.
// Memory responder acks each word after a programmable delay and checks bus stability while waiting.
// Stats expectations follow CACHE_STATS_EN.
module tb_cache_controller;
  localparam int AW = 8;
  localparam int CS = 4;
  localparam int NW = 4;
  localparam int SW = 32;

  logic clk;
  logic rst;
  cache_controller_if #(.addrSize(AW), .sWord(SW)) bus ();

  cache_controller #(.addrSize(AW), .cacheSize(CS), .nWords(NW), .sWord(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] mem_img [256];
  logic [40:0] log_q [$];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [40:0] snap;
  logic [40:0] cur;

  initial begin
    for (int a = 0; a < 256; a++) mem_img[a] = 32'h1000 + a;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    snap          = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req !== 1'b1 || rst) begin
        wait_cnt = 0;
      end else begin
        cur = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0};
        if (wait_cnt == 0) snap = cur;
        else chk("mem_hold", cur, snap);
        if (wait_cnt >= ack_delay) begin
          if (bus.mem_we) mem_img[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = mem_img[bus.mem_addr];
          bus.mem_ack   = 1'b1;
          log_q.push_back(cur);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  logic        m_valid [CS];
  logic        m_dirty [CS];
  logic [3:0]  m_tag   [CS];
  logic [31:0] m_line  [CS][NW];
  int          m_hit, m_miss, m_wb;
  logic [40:0] exp_q [$];
  logic        exp_hit;

  task automatic model_reset();
    for (int i = 0; i < CS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hit = 0; m_miss = 0; m_wb = 0;
  endtask

  // Predicts the memory transactions and read data of one CPU request, and updates the model.
  task automatic model_req(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd);
    logic [1:0] idx, off, w;
    logic [3:0] tg;
    logic [7:0] a;
    idx = addr[3:2]; off = addr[1:0]; tg = addr[7:4];
    exp_q.delete();
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    if (exp_hit) begin
      m_hit++;
    end else begin
      m_miss++;
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int i = 0; i < NW; i++) begin
          w = 2'(i);
          a = {m_tag[idx], idx, w};
          ref_mem[a] = m_line[idx][i];
          exp_q.push_back({1'b1, a, m_line[idx][i]});
        end
        m_wb++;
      end
      for (int i = 0; i < NW; i++) begin
        w = 2'(i);
        a = {tg, idx, w};
        m_line[idx][i] = ref_mem[a];
        exp_q.push_back({1'b0, a, 32'h0});
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      m_line[idx][off] = wd;
      m_dirty[idx]     = 1'b1;
      rd               = wd;
    end else begin
      rd = m_line[idx][off];
    end
  endtask

  // Issues one request, waits for completion and compares against the model.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input int dly, output logic [31:0] rd);
    logic [31:0] exp_rd;
    int          lat, n;
    logic        ready_bad, saw_req;
    model_req(we, addr, wd, exp_rd);
    ack_delay = dly;
    log_q.delete();
    n = 0;
    while (bus.cpu_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", bus.cpu_ready, 1'b1);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_wdata = $urandom;
    chk("ready_busy", bus.cpu_ready, 1'b0);
    lat = 1; ready_bad = 1'b0; saw_req = 1'b0;
    while (bus.cpu_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.mem_req === 1'b1) saw_req = 1'b1;
      if (bus.cpu_valid !== 1'b1 && bus.cpu_ready !== 1'b0) ready_bad = 1'b1;
    end
    chk("valid_timeout", lat < 300, 1'b1);
    chk("ready_low_while_busy", ready_bad, 1'b0);
    rd = bus.cpu_rdata;
    chk("cpu_rdata", rd, exp_rd);
    if (exp_hit) begin
      chk("hit_latency", lat, 2);
      chk("hit_no_mem_req", saw_req, 1'b0);
    end
    @(negedge clk);
    chk("valid_one_cycle", bus.cpu_valid, 1'b0);
    chk("mem_txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk("mem_txn", log_q[i], exp_q[i]);
  endtask

  task automatic chk_stats(input string tag);
`ifdef CACHE_STATS_EN
    chk({tag, "_hit_count"},  bus.hit_count,  m_hit);
    chk({tag, "_miss_count"}, bus.miss_count, m_miss);
    chk({tag, "_wb_count"},   bus.wb_count,   m_wb);
`else
    chk({tag, "_hit_count"},  bus.hit_count,  0);
    chk({tag, "_miss_count"}, bus.miss_count, 0);
    chk({tag, "_wb_count"},   bus.wb_count,   0);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] rd;
  logic [7:0]  ra;
  int          n;
  logic        bad;

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = 32'h1000 + a;
    model_reset();
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cpu_ready", bus.cpu_ready, 1'b1);
    chk("rst_cpu_valid", bus.cpu_valid, 1'b0);
    chk("rst_mem_req",   bus.mem_req,   1'b0);
    chk("rst_mem_we",    bus.mem_we,    1'b0);
    chk_stats("rst");

    // 1: cold read miss
    do_req(1'b0, 8'h05, 32'h0, 0, rd);
    chk("t1_rdata", rd, 32'h1005);
    // 2: hit in the same line
    do_req(1'b0, 8'h06, 32'h0, 0, rd);
    chk("t2_rdata", rd, 32'h1006);
    // 3: write hit, then conflicting read forces write-back of the dirty line
    do_req(1'b1, 8'h06, 32'hDEAD_BEEF, 0, rd);
    chk("t3_wr_rdata", rd, 32'hDEAD_BEEF);
    do_req(1'b0, 8'h46, 32'h0, 0, rd);
    chk("t3_rdata", rd, 32'h1046);
    if (log_q.size() > 2) chk("t3_wb_word2", log_q[2], {1'b1, 8'h06, 32'hDEAD_BEEF});
    else chk("t3_wb_word2_present", log_q.size(), 8);
    chk_stats("seq123");
    // 4: slow memory, dirty victim and refill
    do_req(1'b1, 8'h47, 32'h1234_5678, 0, rd);
    do_req(1'b0, 8'h07, 32'h0, 3, rd);
    chk("t4_rdata", rd, ref_mem[8'h07]);
    do_req(1'b0, 8'h06, 32'h0, 3, rd);
    chk("t4_hit_rdata", rd, 32'hDEAD_BEEF);

    // 5: reset in the middle of a refill
    ack_delay = 2;
    log_q.delete();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h29;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    n = 0;
    while (log_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_word2", n < 100, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_mem_req", bus.mem_req, 1'b0);
    chk("t5_cpu_ready", bus.cpu_ready, 1'b1);
    chk("t5_cpu_valid", bus.cpu_valid, 1'b0);
    rst = 1'b0;
    model_reset();
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.cpu_valid !== 1'b0 || bus.mem_req !== 1'b0) bad = 1'b1;
    end
    chk("t5_no_valid_after_abort", bad, 1'b0);
    chk_stats("t5_cleared");
    do_req(1'b0, 8'h29, 32'h0, 0, rd);
    chk("t5_reread_miss", exp_q.size(), 4);
    chk("t5_rdata", rd, 32'h1029);

    // Random mix over three tags so hits, clean and dirty misses all occur.
    for (int k = 0; k < 40; k++) begin
      ra = {2'b00, 2'($urandom_range(0, 2)), 2'($urandom), 2'($urandom)};
      do_req(1'($urandom), ra, $urandom, $urandom_range(0, 2), rd);
    end
    chk_stats("random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
